// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants and the fetch FSM state type
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - program counter flop, async reset to RESET_PC, sync enable
module pc_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] q_o
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_o <= RESET_PC;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V fetch stage: PC, next-PC mux, IF/ID register, RUN/HALT FSM
// Optional perf counters fetch_cnt/bubble_cnt under FETCH_PERF_CNT_EN.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic        fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic        pc_en;
  logic [31:0] pc_next;
  logic [31:0] pcplus4_f;
  logic        load_bubble;
  logic        load_fetch;

  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_pcplus4_q;
  logic        if_valid_q;

  assign pcplus4_f = pc_f + 32'd4;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (pc_en),
    .d_i   (pc_next),
    .q_o   (pc_f)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect outranks stall_f; a misaligned target freezes the PC and halts.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    pc_next     = pcplus4_f;
    load_bubble = 1'b1;
    load_fetch  = 1'b0;
    if (state_q == FS_RUN) begin
      if (pc_src_e) begin
        if (pc_target_e[1:0] == 2'b00) begin
          pc_en   = 1'b1;
          pc_next = pc_target_e;
        end else begin
          state_d = FS_HALT;
        end
      end else begin
        pc_en = !stall_f;
      end
      load_bubble = flush_d || pc_src_e;
      load_fetch  = !load_bubble && !stall_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= '0;
      if_pcplus4_q <= '0;
      if_valid_q   <= 1'b0;
    end else if (load_bubble) begin
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= '0;
      if_pcplus4_q <= '0;
      if_valid_q   <= 1'b0;
    end else if (load_fetch) begin
      if_instr_q   <= instr_f;
      if_pc_q      <= pc_f;
      if_pcplus4_q <= pcplus4_f;
      if_valid_q   <= 1'b1;
    end
  end

  assign instr_d   = if_instr_q;
  assign pc_d      = if_pc_q;
  assign pcplus4_d = if_pcplus4_q;
  assign valid_d   = if_valid_q;
  assign fault     = (state_q == FS_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (load_fetch) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage (counters under FETCH_PERF_CNT_EN)
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic        fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 + (a >> 2);
  endfunction

  assign instr_f = mem_word(pc_f);

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .instr_f     (instr_f),
    .pc_f        (pc_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pcplus4_d   (pcplus4_d),
    .valid_d     (valid_d),
    .fault       (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    n_total++; if (pc_f !== 32'h0) $display("FAIL rst_pc: got %h want %h", pc_f, 32'h0); else n_pass++;
    n_total++; if (instr_d !== NOP) $display("FAIL rst_instr: got %h want %h", instr_d, NOP); else n_pass++;
    n_total++; if (valid_d !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid_d); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault); else n_pass++;
    tick();
    n_total++; if (pc_f !== 32'h0) $display("FAIL rst_pc_hold: got %h want %h", pc_f, 32'h0); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_free_run;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_total++; if (pc_f !== 32'(4 * k)) $display("FAIL run_pc[%0d]: got %h want %h", k, pc_f, 32'(4 * k)); else n_pass++;
      n_total++; if (instr_d !== mem_word(32'(4 * (k - 1)))) $display("FAIL run_instr[%0d]: got %h want %h", k, instr_d, mem_word(32'(4 * (k - 1)))); else n_pass++;
      n_total++; if (pc_d !== 32'(4 * (k - 1))) $display("FAIL run_pcd[%0d]: got %h want %h", k, pc_d, 32'(4 * (k - 1))); else n_pass++;
      n_total++; if (pcplus4_d !== 32'(4 * k)) $display("FAIL run_pc4[%0d]: got %h want %h", k, pcplus4_d, 32'(4 * k)); else n_pass++;
      n_total++; if (valid_d !== 1'b1) $display("FAIL run_valid[%0d]: got %b want 1", k, valid_d); else n_pass++;
    end
  endtask

  task automatic test_stall;
    stall_f = 1'b1;
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (pc_f !== 32'h10) $display("FAIL stall_pc[%0d]: got %h want %h", i, pc_f, 32'h10); else n_pass++;
      n_total++; if (pc_d !== 32'hC) $display("FAIL stall_pcd[%0d]: got %h want %h", i, pc_d, 32'hC); else n_pass++;
      n_total++; if (instr_d !== mem_word(32'hC)) $display("FAIL stall_instr[%0d]: got %h want %h", i, instr_d, mem_word(32'hC)); else n_pass++;
    end
    stall_f = 1'b0;
    stall_d = 1'b0;
    tick();
    n_total++; if (pc_f !== 32'h14) $display("FAIL resume_pc: got %h want %h", pc_f, 32'h14); else n_pass++;
    n_total++; if (pc_d !== 32'h10) $display("FAIL resume_pcd: got %h want %h", pc_d, 32'h10); else n_pass++;
    n_total++; if (instr_d !== mem_word(32'h10)) $display("FAIL resume_instr: got %h want %h", instr_d, mem_word(32'h10)); else n_pass++;
    tick();
    n_total++; if (pc_d !== 32'h14) $display("FAIL resume_next_pcd: got %h want %h", pc_d, 32'h14); else n_pass++;
  endtask

  task automatic test_redirect;
    pc_src_e = 1'b1;
    pc_target_e = 32'h40;
    stall_f = 1'b1;
    tick();
    pc_src_e = 1'b0;
    stall_f = 1'b0;
    n_total++; if (pc_f !== 32'h40) $display("FAIL redir_pc: got %h want %h", pc_f, 32'h40); else n_pass++;
    n_total++; if (valid_d !== 1'b0) $display("FAIL redir_squash: got %b want 0", valid_d); else n_pass++;
    tick();
    n_total++; if (instr_d !== mem_word(32'h40)) $display("FAIL redir_instr: got %h want %h", instr_d, mem_word(32'h40)); else n_pass++;
    n_total++; if (pc_d !== 32'h40) $display("FAIL redir_pcd: got %h want %h", pc_d, 32'h40); else n_pass++;
    n_total++; if (valid_d !== 1'b1) $display("FAIL redir_valid: got %b want 1", valid_d); else n_pass++;
    n_total++; if (pc_f !== 32'h44) $display("FAIL redir_next_pc: got %h want %h", pc_f, 32'h44); else n_pass++;
  endtask

  task automatic test_flush_vs_stall;
    flush_d = 1'b1;
    stall_d = 1'b1;
    stall_f = 1'b1;
    tick();
    flush_d = 1'b0;
    stall_d = 1'b0;
    stall_f = 1'b0;
    n_total++; if (valid_d !== 1'b0) $display("FAIL flush_valid: got %b want 0", valid_d); else n_pass++;
    n_total++; if (instr_d !== NOP) $display("FAIL flush_instr: got %h want %h", instr_d, NOP); else n_pass++;
    n_total++; if (pc_d !== 32'h0) $display("FAIL flush_pcd: got %h want 0", pc_d); else n_pass++;
    n_total++; if (pcplus4_d !== 32'h0) $display("FAIL flush_pc4: got %h want 0", pcplus4_d); else n_pass++;
    n_total++; if (pc_f !== 32'h44) $display("FAIL flush_pc_hold: got %h want %h", pc_f, 32'h44); else n_pass++;
    tick();
    n_total++; if (pc_d !== 32'h44) $display("FAIL flush_resume_pcd: got %h want %h", pc_d, 32'h44); else n_pass++;
  endtask

  task automatic test_pc_wrap;
    pc_src_e = 1'b1;
    pc_target_e = 32'hFFFF_FFFC;
    tick();
    pc_src_e = 1'b0;
    n_total++; if (pc_f !== 32'hFFFF_FFFC) $display("FAIL wrap_target: got %h want %h", pc_f, 32'hFFFF_FFFC); else n_pass++;
    tick();
    n_total++; if (pc_f !== 32'h0) $display("FAIL wrap_pc: got %h want 0", pc_f); else n_pass++;
    n_total++; if (pc_d !== 32'hFFFF_FFFC) $display("FAIL wrap_pcd: got %h want %h", pc_d, 32'hFFFF_FFFC); else n_pass++;
    n_total++; if (pcplus4_d !== 32'h0) $display("FAIL wrap_pc4: got %h want 0", pcplus4_d); else n_pass++;
    n_total++; if (instr_d !== 32'h4010_0092) $display("FAIL wrap_instr: got %h want %h", instr_d, 32'h4010_0092); else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_misaligned;
    pc_src_e = 1'b1;
    pc_target_e = 32'h42;
    tick();
    pc_src_e = 1'b0;
    n_total++; if (fault !== 1'b1) $display("FAIL mis_fault: got %b want 1", fault); else n_pass++;
    n_total++; if (pc_f !== 32'h8) $display("FAIL mis_pc: got %h want %h", pc_f, 32'h8); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        pc_src_e = 1'b1;
        pc_target_e = 32'h80;
      end
      tick();
      pc_src_e = 1'b0;
      n_total++; if (pc_f !== 32'h8) $display("FAIL halt_pc[%0d]: got %h want %h", i, pc_f, 32'h8); else n_pass++;
      n_total++; if (valid_d !== 1'b0) $display("FAIL halt_valid[%0d]: got %b want 0", i, valid_d); else n_pass++;
      n_total++; if (fault !== 1'b1) $display("FAIL halt_fault[%0d]: got %b want 1", i, fault); else n_pass++;
    end
    #2 reset = 1'b1;
    #1;
    n_total++; if (fault !== 1'b0) $display("FAIL async_rst_fault: got %b want 0", fault); else n_pass++;
    n_total++; if (pc_f !== 32'h0) $display("FAIL async_rst_pc: got %h want 0", pc_f); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_total++; if (pc_f !== 32'h4) $display("FAIL post_rst_pc: got %h want 4", pc_f); else n_pass++;
    n_total++; if (valid_d !== 1'b1) $display("FAIL post_rst_valid: got %b want 1", valid_d); else n_pass++;
    n_total++; if (instr_d !== mem_word(32'h0)) $display("FAIL post_rst_instr: got %h want %h", instr_d, mem_word(32'h0)); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL post_rst_fault: got %b want 0", fault); else n_pass++;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_counters;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++; if (fetch_cnt !== 32'h0) $display("FAIL cnt_rst_fetch: got %0d want 0", fetch_cnt); else n_pass++;
    n_total++; if (bubble_cnt !== 32'h0) $display("FAIL cnt_rst_bubble: got %0d want 0", bubble_cnt); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) tick();
    flush_d = 1'b1;
    tick();
    tick();
    flush_d = 1'b0;
    n_total++; if (fetch_cnt !== 32'd8) $display("FAIL cnt_fetch: got %0d want 8", fetch_cnt); else n_pass++;
    n_total++; if (bubble_cnt !== 32'd2) $display("FAIL cnt_bubble: got %0d want 2", bubble_cnt); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_flush_vs_stall();
    test_pc_wrap();
    test_misaligned();
`ifdef FETCH_PERF_CNT_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
